// File: rtl/fft_pkg.sv
// fft_pkg - shared constants and types for the radix-2 FFT datapath.
//   FFT_DW / FFT_TW : default data / twiddle widths
//   TW_FRAC, TW_ONE : twiddle format Q1.14 (+1.0 = 16'h4000)
//   SAT_MAX/SAT_MIN : saturation limits for FFT_DW-bit results
//   cplx_t          : complex sample {re, im}
package fft_pkg;
    localparam int FFT_DW  = 16;
    localparam int FFT_TW  = 16;
    localparam int TW_FRAC = 14;
    localparam logic [FFT_TW-1:0] TW_ONE = 16'h4000;
    localparam logic signed [FFT_DW-1:0] SAT_MAX = {1'b0, {(FFT_DW-1){1'b1}}};
    localparam logic signed [FFT_DW-1:0] SAT_MIN = {1'b1, {(FFT_DW-1){1'b0}}};

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;
endpackage

// File: rtl/fft_cmult.sv
// fft_cmult - 2-stage registered complex multiplier b*W.
//   P1: four partial products (DW x TW).
//   P2: re = ac-bd, im = ad+bc, rounded (+2^(TW_FRAC-1), >>>TW_FRAC) to DW+2 bits.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_b_re, i_b_im      operand b (DW signed)
//   i_w_re, i_w_im      twiddle W (TW signed, Q1.14)
//   o_re, o_im          registered product, DW+2 bits, valid 2 cycles after inputs
module fft_cmult
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int TW = FFT_TW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] i_b_re,
    input  logic signed [DW-1:0] i_b_im,
    input  logic signed [TW-1:0] i_w_re,
    input  logic signed [TW-1:0] i_w_im,
    output logic signed [DW+1:0] o_re,
    output logic signed [DW+1:0] o_im
);
    localparam int PW = DW + TW;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] HALF = SW'(1) << (TW_FRAC - 1);

    logic signed [PW-1:0] r_ac, r_bd, r_ad, r_bc;
    logic signed [DW+1:0] r_re, r_im;
    logic signed [SW-1:0] w_re_sum, w_im_sum, w_re_rnd, w_im_rnd;

    // Clamp to DW+2 bits; only reachable with |W| near 2.0, but keeps the
    // narrow result from wrapping.
    function automatic logic signed [DW+1:0] clip(input logic signed [SW-1:0] v);
        if ((&v[SW-1:DW+1]) || !(|v[SW-1:DW+1]))
            return v[DW+1:0];
        return v[SW-1] ? {1'b1, {(DW+1){1'b0}}} : {1'b0, {(DW+1){1'b1}}};
    endfunction

    assign w_re_sum = SW'(r_ac) - SW'(r_bd);
    assign w_im_sum = SW'(r_ad) + SW'(r_bc);
    // Add-half then arithmetic shift: ties round toward +inf.
    assign w_re_rnd = (w_re_sum + HALF) >>> TW_FRAC;
    assign w_im_rnd = (w_im_sum + HALF) >>> TW_FRAC;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ac <= '0;
            r_bd <= '0;
            r_ad <= '0;
            r_bc <= '0;
            r_re <= '0;
            r_im <= '0;
        end else begin
            r_ac <= i_b_re * i_w_re;
            r_bd <= i_b_im * i_w_im;
            r_ad <= i_b_re * i_w_im;
            r_bc <= i_b_im * i_w_re;
            r_re <= clip(w_re_rnd);
            r_im <= clip(w_im_rnd);
        end
    end

    assign o_re = r_re;
    assign o_im = r_im;
endmodule

// File: rtl/fft_butterfly.sv
// fft_butterfly - radix-2 DIT butterfly: y1 = a + b*W, y2 = a - b*W.
// Fully pipelined, one butterfly per clock, latency RD_LAT+3 from en_multi.
// Optional macro BFLY_SCALE_EN: results rounded >>1 before saturation.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en_multi                 op start, sampled with factor_re/im
//   factor_re, factor_im     twiddle W (Q1.14), delayed RD_LAT to meet rd_data
//   rd_data1_re/_im          operand a, valid RD_LAT cycles after en_multi
//   rd_data2_re/_im          operand b, valid RD_LAT cycles after en_multi
//   wr_data1_re/_im          y1, held between ops
//   wr_data2_re/_im          y2, held between ops
//   butterfly_finish_flag    1-cycle pulse when wr_data* updated
//   ovf_flag, ovf_clr        sticky saturation flag and its clear (set wins)
module fft_butterfly
    import fft_pkg::*;
#(
    parameter int DW     = FFT_DW,
    parameter int TW     = FFT_TW,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_multi,
    input  logic signed [TW-1:0] factor_re,
    input  logic signed [TW-1:0] factor_im,
    input  logic signed [DW-1:0] rd_data1_re,
    input  logic signed [DW-1:0] rd_data1_im,
    input  logic signed [DW-1:0] rd_data2_re,
    input  logic signed [DW-1:0] rd_data2_im,
    output logic signed [DW-1:0] wr_data1_re,
    output logic signed [DW-1:0] wr_data1_im,
    output logic signed [DW-1:0] wr_data2_re,
    output logic signed [DW-1:0] wr_data2_im,
    output logic                 butterfly_finish_flag,
    output logic                 ovf_flag,
    input  logic                 ovf_clr
);
    localparam int NV = RD_LAT + 3;
    localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    // r_vld_pipe[k] set means an op was sampled k edges ago.
    logic [NV:0]          r_vld_pipe;
    logic signed [TW-1:0] r_tw_re [RD_LAT];
    logic signed [TW-1:0] r_tw_im [RD_LAT];
    logic signed [TW-1:0] r_w_re, r_w_im;
    logic signed [DW-1:0] r_a_re, r_a_im, r_b_re, r_b_im;
    logic signed [DW-1:0] r_a1_re, r_a1_im, r_a2_re, r_a2_im;
    logic signed [DW-1:0] r_y1_re, r_y1_im, r_y2_re, r_y2_im;
    logic                 r_ovf;
    logic signed [DW+1:0] w_bw_re, w_bw_im;
    logic signed [DW+2:0] w_y1_re, w_y1_im, w_y2_re, w_y2_im;
    logic                 w_sat;

    function automatic logic signed [DW+2:0] scl(input logic signed [DW+2:0] v);
`ifdef BFLY_SCALE_EN
        return (v + (DW+3)'(1)) >>> 1;
`else
        return v;
`endif
    endfunction

    function automatic logic out_rng(input logic signed [DW+2:0] v);
        return !((&v[DW+2:DW-1]) || !(|v[DW+2:DW-1]));
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [DW+2:0] v);
        if (out_rng(v))
            return v[DW+2] ? SMIN : SMAX;
        return v[DW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tw_re[i] <= '0;
                r_tw_im[i] <= '0;
            end
        end else begin
            r_vld_pipe <= {r_vld_pipe[NV-1:0], en_multi};
            r_tw_re[0] <= factor_re;
            r_tw_im[0] <= factor_im;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tw_re[i] <= r_tw_re[i-1];
                r_tw_im[i] <= r_tw_im[i-1];
            end
        end
    end

    // Operand capture and the a-path delay that tracks the multiplier stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_re  <= '0;
            r_w_im  <= '0;
            r_a_re  <= '0;
            r_a_im  <= '0;
            r_b_re  <= '0;
            r_b_im  <= '0;
            r_a1_re <= '0;
            r_a1_im <= '0;
            r_a2_re <= '0;
            r_a2_im <= '0;
        end else begin
            r_w_re  <= r_tw_re[RD_LAT-1];
            r_w_im  <= r_tw_im[RD_LAT-1];
            r_a_re  <= rd_data1_re;
            r_a_im  <= rd_data1_im;
            r_b_re  <= rd_data2_re;
            r_b_im  <= rd_data2_im;
            r_a1_re <= r_a_re;
            r_a1_im <= r_a_im;
            r_a2_re <= r_a1_re;
            r_a2_im <= r_a1_im;
        end
    end

    fft_cmult #(.DW(DW), .TW(TW)) u_cmult (
        .clk    (clk),
        .rst    (rst),
        .i_b_re (r_b_re),
        .i_b_im (r_b_im),
        .i_w_re (r_w_re),
        .i_w_im (r_w_im),
        .o_re   (w_bw_re),
        .o_im   (w_bw_im)
    );

    assign w_y1_re = scl((DW+3)'(r_a2_re) + (DW+3)'(w_bw_re));
    assign w_y1_im = scl((DW+3)'(r_a2_im) + (DW+3)'(w_bw_im));
    assign w_y2_re = scl((DW+3)'(r_a2_re) - (DW+3)'(w_bw_re));
    assign w_y2_im = scl((DW+3)'(r_a2_im) - (DW+3)'(w_bw_im));
    assign w_sat   = out_rng(w_y1_re) | out_rng(w_y1_im) |
                     out_rng(w_y2_re) | out_rng(w_y2_im);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y1_re <= '0;
            r_y1_im <= '0;
            r_y2_re <= '0;
            r_y2_im <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_vld_pipe[NV-1]) begin
                r_y1_re <= sat(w_y1_re);
                r_y1_im <= sat(w_y1_im);
                r_y2_re <= sat(w_y2_re);
                r_y2_im <= sat(w_y2_im);
            end
            if (r_vld_pipe[NV-1] && w_sat)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign wr_data1_re           = r_y1_re;
    assign wr_data1_im           = r_y1_im;
    assign wr_data2_re           = r_y2_re;
    assign wr_data2_im           = r_y2_im;
    assign butterfly_finish_flag = r_vld_pipe[NV];
    assign ovf_flag              = r_ovf;
endmodule

// File: tb/tb_fft_butterfly.sv
// tb_fft_butterfly - randomized + directed check of fft_butterfly against a
// per-op arithmetic reference model (complex math, round, scale, saturate).
module tb_fft_butterfly;
    import fft_pkg::*;

    localparam int RD_LAT = 2;
    localparam int L      = RD_LAT + 3;
    localparam int NCYC   = 420;

    logic clk = 1'b0;
    logic rst, en_multi, ovf_clr;
    logic signed [15:0] factor_re, factor_im;
    logic signed [15:0] rd_data1_re, rd_data1_im, rd_data2_re, rd_data2_im;
    logic signed [15:0] wr_data1_re, wr_data1_im, wr_data2_re, wr_data2_im;
    logic butterfly_finish_flag, ovf_flag;

    always #5 clk = ~clk;

    fft_butterfly #(.DW(16), .TW(16), .RD_LAT(RD_LAT)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .en_multi              (en_multi),
        .factor_re             (factor_re),
        .factor_im             (factor_im),
        .rd_data1_re           (rd_data1_re),
        .rd_data1_im           (rd_data1_im),
        .rd_data2_re           (rd_data2_re),
        .rd_data2_im           (rd_data2_im),
        .wr_data1_re           (wr_data1_re),
        .wr_data1_im           (wr_data1_im),
        .wr_data2_re           (wr_data2_re),
        .wr_data2_im           (wr_data2_im),
        .butterfly_finish_flag (butterfly_finish_flag),
        .ovf_flag              (ovf_flag),
        .ovf_clr               (ovf_clr)
    );

    // Per-edge stimulus schedule.
    bit    s_en  [NCYC];
    bit    s_rst [NCYC];
    bit    s_clr [NCYC];
    cplx_t s_a [NCYC], s_b [NCYC], s_w [NCYC];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic put_op(input int n, input int ar, input int ai, input int br,
                          input int bi, input int wr, input int wi);
        s_en[n]   = 1'b1;
        s_a[n].re = 16'(ar);
        s_a[n].im = 16'(ai);
        s_b[n].re = 16'(br);
        s_b[n].im = 16'(bi);
        s_w[n].re = 16'(wr);
        s_w[n].im = 16'(wi);
    endtask

    // Round x/2^14 to nearest, ties toward +inf.
    function automatic longint rnd14(input longint x);
        return (x + 64'sd8192) >>> 14;
    endfunction

    // Optional halving (ties toward +inf) then clamp to 16-bit signed.
    function automatic int fin(input longint v, inout bit s);
        longint t;
        t = v;
`ifdef BFLY_SCALE_EN
        t = (v + 64'sd1) >>> 1;
`endif
        if (t > 32767)  begin s = 1'b1; return 32767;  end
        if (t < -32768) begin s = 1'b1; return -32768; end
        return int'(t);
    endfunction

    initial begin
        int e_y1r, e_y1i, e_y2r, e_y2i;
        bit e_flag, e_ovf;

        for (int n = 0; n < NCYC; n++) begin
            s_en[n] = 0; s_rst[n] = 0; s_clr[n] = 0;
            s_a[n] = '0; s_b[n] = '0; s_w[n] = '0;
        end
        for (int n = 0; n < 4; n++) s_rst[n] = 1'b1;

        put_op(8,  100, 0, 50, 0, 16384, 0);            // W = 1
        put_op(12, 0, 0, 1000, 0, 0, -16384);           // W = -j
        put_op(16, 32767, 0, 32767, 0, 16384, 0);       // saturating (unscaled)
        s_clr[26] = 1'b1;                               // clear alone
        put_op(30, 1234, -567, -2000, 3000, 11585, -11585);
        put_op(31, -32768, 32767, 100, -100, 0, 16384);
        put_op(32, 5, -5, 32767, -32768, -16384, 0);
        put_op(40, 777, 888, 999, 111, 16384, 0);       // killed by rst
        s_rst[42] = 1'b1;
        put_op(46, -300, 400, 250, -125, 8192, 8192);
        put_op(50, 32767, 0, 32767, 0, 32767, 0);       // saturates in both builds
        s_clr[55] = 1'b1;                               // same edge as saturation
        s_clr[58] = 1'b1;
        for (int n = 62; n < NCYC - 20; n++) begin
            if (n >= 198 && n <= 206) continue;
            if ($urandom_range(0, 9) < 6)
                put_op(n, int'(16'($urandom)) - 32768 + 32768 * 0 + int'($signed(16'($urandom))) * 0,
                       int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                       int'($signed(16'($urandom))),
                       int'($urandom_range(0, 32768)) - 16384,
                       int'($urandom_range(0, 32768)) - 16384);
            if ($urandom_range(0, 19) == 0) s_clr[n] = 1'b1;
        end
        s_rst[200] = 1'b1;
        s_rst[201] = 1'b1;

        e_y1r = 0; e_y1i = 0; e_y2r = 0; e_y2i = 0; e_flag = 0; e_ovf = 0;
        rst = 1'b1; en_multi = 1'b0; ovf_clr = 1'b0;
        factor_re = '0; factor_im = '0;
        rd_data1_re = '0; rd_data1_im = '0; rd_data2_re = '0; rd_data2_im = '0;

        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            rst       = s_rst[n];
            en_multi  = s_en[n];
            ovf_clr   = s_clr[n];
            factor_re = s_w[n].re;
            factor_im = s_w[n].im;
            if (n >= RD_LAT && s_en[n-RD_LAT]) begin
                rd_data1_re = s_a[n-RD_LAT].re;
                rd_data1_im = s_a[n-RD_LAT].im;
                rd_data2_re = s_b[n-RD_LAT].re;
                rd_data2_im = s_b[n-RD_LAT].im;
            end else begin
                rd_data1_re = 16'($urandom);
                rd_data1_im = 16'($urandom);
                rd_data2_re = 16'($urandom);
                rd_data2_im = 16'($urandom);
            end
            @(posedge clk);
            #1;
            // Reference for the state after edge n.
            if (s_rst[n]) begin
                e_y1r = 0; e_y1i = 0; e_y2r = 0; e_y2i = 0; e_flag = 0; e_ovf = 0;
            end else begin
                int  m;
                bit  live, s;
                longint ar, ai, br, bi, wr, wi, pr, pi;
                m    = n - L;
                live = (m >= 0) && s_en[m];
                if (live)
                    for (int k = m; k <= n; k++) if (s_rst[k]) live = 0;
                e_flag = live;
                s = 1'b0;
                if (live) begin
                    ar = s_a[m].re; ai = s_a[m].im;
                    br = s_b[m].re; bi = s_b[m].im;
                    wr = s_w[m].re; wi = s_w[m].im;
                    pr = rnd14(br * wr - bi * wi);
                    pi = rnd14(br * wi + bi * wr);
                    e_y1r = fin(ar + pr, s);
                    e_y1i = fin(ai + pi, s);
                    e_y2r = fin(ar - pr, s);
                    e_y2i = fin(ai - pi, s);
                end
                if (live && s)       e_ovf = 1'b1;
                else if (s_clr[n])   e_ovf = 1'b0;
            end
            chk($sformatf("flag@%0d", n), 32'(butterfly_finish_flag), 32'(e_flag));
            chk($sformatf("ovf@%0d", n),  32'(ovf_flag), 32'(e_ovf));
            chk($sformatf("y1re@%0d", n), 32'(wr_data1_re), e_y1r);
            chk($sformatf("y1im@%0d", n), 32'(wr_data1_im), e_y1i);
            chk($sformatf("y2re@%0d", n), 32'(wr_data2_re), e_y2r);
            chk($sformatf("y2im@%0d", n), 32'(wr_data2_im), e_y2i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
